// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into a screen-clamped cursor position and button state.
// Optional inter-byte timeout: define MOUSE_DECODER_TIMEOUT_EN.
module ps2_mouse_packet_decoder #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [9:0] x_position,
  output logic [8:0] y_position,
  output logic       left_pressed,
  output logic       right_pressed,
  output logic       middle_pressed,
  output logic       mousePressed,
  output logic       packet_valid,
  output logic       sync_error
);

  // state   | meaning
  // WAIT_B0 | hunting for a status byte (bit3 set), ACK 0xFA ignored
  // WAIT_B1 | status latched, waiting for the dx byte
  // WAIT_B2 | dx latched, waiting for the dy byte
  // UPDATE  | apply movement and buttons, pulse packet_valid
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

  localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - 1);
  localparam logic [8:0]  Y_MAX  = 9'(SCREEN_H - 1);
  localparam logic [9:0]  X_RST  = 10'(X_INIT);
  localparam logic [8:0]  Y_RST  = 9'(Y_INIT);

  state_t     state_q, state_d, state_eff;
  // status bits kept: [6] Y ovf, [5] X ovf, [4] Y sign, [3] X sign, [2] M, [1] R, [0] L
  logic [6:0] status_q, status_d;
  logic [7:0] dx_q, dx_d, dy_q, dy_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       left_q, left_d, right_q, right_d, middle_q, middle_d;
  logic       pressed_q, pressed_d, valid_q, valid_d, sync_err_q, sync_err_d;
  logic [11:0] x_sum, y_dif;
  logic [9:0]  x_clamped;
  logic [8:0]  y_clamped;
  logic        timeout_hit;

`ifdef MOUSE_DECODER_TIMEOUT_EN
  localparam logic [17:0] GAP_LOAD = 18'(TIMEOUT_CYCLES - 1);
  logic [17:0] gap_q, gap_d;
  logic        collecting;

  assign collecting  = (state_q == WAIT_B1) || (state_q == WAIT_B2);
  assign timeout_hit = collecting && (gap_q == 18'd0);

  always_comb begin
    gap_d = gap_q - 18'd1;
    if (received_data_en || !collecting || timeout_hit) gap_d = GAP_LOAD;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Movement is evaluated in 12 bits so underflow shows up in bit 11.
  always_comb begin
    x_sum = {2'b00, x_q} + {{4{status_q[3]}}, dx_q};
    y_dif = {3'b000, y_q} - {{4{status_q[4]}}, dy_q};

    if (x_sum[11])                    x_clamped = 10'd0;
    else if (x_sum > {2'b00, X_MAX})  x_clamped = X_MAX;
    else                              x_clamped = x_sum[9:0];

    if (y_dif[11])                    y_clamped = 9'd0;
    else if (y_dif > {3'b000, Y_MAX}) y_clamped = Y_MAX;
    else                              y_clamped = y_dif[8:0];
  end

  always_comb begin
    state_eff  = timeout_hit ? WAIT_B0 : state_q;
    state_d    = state_eff;
    status_d   = status_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    x_d        = x_q;
    y_d        = y_q;
    left_d     = left_q;
    right_d    = right_q;
    middle_d   = middle_q;
    pressed_d  = 1'b0;
    valid_d    = 1'b0;
    sync_err_d = timeout_hit;

    case (state_eff)
      WAIT_B0: begin
        if (received_data_en && received_data != 8'hFA) begin
          if (!received_data[3]) begin
            sync_err_d = 1'b1;
          end else begin
            status_d = {received_data[7:4], received_data[2:0]};
            state_d  = WAIT_B1;
          end
        end
      end
      WAIT_B1: begin
        if (received_data_en) begin
          dx_d    = received_data;
          state_d = WAIT_B2;
        end
      end
      WAIT_B2: begin
        if (received_data_en) begin
          dy_d    = received_data;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (!status_q[5]) x_d = x_clamped;
        if (!status_q[6]) y_d = y_clamped;
        left_d    = status_q[0];
        right_d   = status_q[1];
        middle_d  = status_q[2];
        pressed_d = status_q[0] && !left_q;
        valid_d   = 1'b1;
        state_d   = WAIT_B0;
      end
      default: state_d = WAIT_B0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= WAIT_B0;
      status_q   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      x_q        <= X_RST;
      y_q        <= Y_RST;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      middle_q   <= 1'b0;
      pressed_q  <= 1'b0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef MOUSE_DECODER_TIMEOUT_EN
      gap_q      <= GAP_LOAD;
`endif
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      left_q     <= left_d;
      right_q    <= right_d;
      middle_q   <= middle_d;
      pressed_q  <= pressed_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
`ifdef MOUSE_DECODER_TIMEOUT_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign x_position     = x_q;
  assign y_position     = y_q;
  assign left_pressed   = left_q;
  assign right_pressed  = right_q;
  assign middle_pressed = middle_q;
  assign mousePressed   = pressed_q;
  assign packet_valid   = valid_q;
  assign sync_error     = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed self-checking bench for ps2_mouse_packet_decoder (default build, no timeout).
module tb_ps2_mouse_packet_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [9:0] x_position;
  logic [8:0] y_position;
  logic       left_pressed, right_pressed, middle_pressed;
  logic       mousePressed, packet_valid, sync_error;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_mouse_packet_decoder dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .x_position      (x_position),
    .y_position      (y_position),
    .left_pressed    (left_pressed),
    .right_pressed   (right_pressed),
    .middle_pressed  (middle_pressed),
    .mousePressed    (mousePressed),
    .packet_valid    (packet_valid),
    .sync_error      (sync_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    received_data_en = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  // Strobe is sampled on the first edge after it is raised; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    received_data = b;
    received_data_en = 1'b1;
    @(posedge CLOCK_50); #1;
    received_data_en = 1'b0;
    received_data = 8'h00;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             output logic pv_upd, output logic pv_out, output logic mp_out,
                             output logic pv_after, output logic mp_after);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    pv_upd = packet_valid;
    @(posedge CLOCK_50); #1;
    pv_out = packet_valid;
    mp_out = mousePressed;
    @(posedge CLOCK_50); #1;
    pv_after = packet_valid;
    mp_after = mousePressed;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (x_position !== 10'd320) begin n_bad++; $display("FAIL reset_x: got %0d expected 320", x_position); end
    n_cmp++; if (y_position !== 9'd240) begin n_bad++; $display("FAIL reset_y: got %0d expected 240", y_position); end
    n_cmp++; if ({left_pressed, right_pressed, middle_pressed} !== 3'b000) begin n_bad++; $display("FAIL reset_buttons: got %b expected 000", {left_pressed, right_pressed, middle_pressed}); end
    n_cmp++; if ({mousePressed, packet_valid, sync_error} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 000", {mousePressed, packet_valid, sync_error}); end
  endtask

  task automatic test_basic();
    logic pu, po, mo, pa, ma;
    do_reset();
    send_byte(8'h08);
    send_byte(8'h05);
    n_cmp++; if (x_position !== 10'd320) begin n_bad++; $display("FAIL basic_hold_x: got %0d expected 320", x_position); end
    send_byte(8'h03);
    pu = packet_valid;
    n_cmp++; if (pu !== 1'b0) begin n_bad++; $display("FAIL basic_pv_early: got %b expected 0", pu); end
    @(posedge CLOCK_50); #1;
    po = packet_valid;
    n_cmp++; if (po !== 1'b1) begin n_bad++; $display("FAIL basic_pv: got %b expected 1", po); end
    n_cmp++; if (x_position !== 10'd325) begin n_bad++; $display("FAIL basic_x: got %0d expected 325", x_position); end
    n_cmp++; if (y_position !== 9'd237) begin n_bad++; $display("FAIL basic_y: got %0d expected 237", y_position); end
    @(posedge CLOCK_50); #1;
    pa = packet_valid;
    n_cmp++; if (pa !== 1'b0) begin n_bad++; $display("FAIL basic_pv_once: got %b expected 0", pa); end
    n_cmp++; if ({left_pressed, right_pressed, middle_pressed} !== 3'b000) begin n_bad++; $display("FAIL basic_buttons: got %b expected 000", {left_pressed, right_pressed, middle_pressed}); end
  endtask

  task automatic test_negative();
    logic pu, po, mo, pa, ma;
    do_reset();
    send_packet(8'h38, 8'hFB, 8'hFE, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd315) begin n_bad++; $display("FAIL neg_x: got %0d expected 315", x_position); end
    n_cmp++; if (y_position !== 9'd242) begin n_bad++; $display("FAIL neg_y: got %0d expected 242", y_position); end
    n_cmp++; if (sync_error !== 1'b0) begin n_bad++; $display("FAIL neg_sync: got %b expected 0", sync_error); end
  endtask

  task automatic test_clamp();
    logic pu, po, mo, pa, ma;
    do_reset();
    send_packet(8'h18, 8'h00, 8'h00, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd64) begin n_bad++; $display("FAIL clamp_x256: got %0d expected 64", x_position); end
    send_packet(8'h28, 8'h00, 8'h80, pu, po, mo, pa, ma);
    n_cmp++; if (y_position !== 9'd368) begin n_bad++; $display("FAIL clamp_y368: got %0d expected 368", y_position); end
    send_packet(8'h38, 8'h80, 8'h80, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd0) begin n_bad++; $display("FAIL clamp_x0: got %0d expected 0", x_position); end
    n_cmp++; if (y_position !== 9'd479) begin n_bad++; $display("FAIL clamp_y479: got %0d expected 479", y_position); end
    send_packet(8'h38, 8'h80, 8'h80, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd0) begin n_bad++; $display("FAIL clamp_x0_hold: got %0d expected 0", x_position); end
    n_cmp++; if (y_position !== 9'd479) begin n_bad++; $display("FAIL clamp_y479_hold: got %0d expected 479", y_position); end
    for (int i = 0; i < 3; i++) send_packet(8'h08, 8'hFF, 8'hFF, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd639) begin n_bad++; $display("FAIL clamp_x639: got %0d expected 639", x_position); end
    n_cmp++; if (y_position !== 9'd0) begin n_bad++; $display("FAIL clamp_ytop: got %0d expected 0", y_position); end
  endtask

  task automatic test_overflow();
    logic pu, po, mo, pa, ma;
    do_reset();
    send_packet(8'h48, 8'h10, 8'h04, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd320) begin n_bad++; $display("FAIL ovf_x: got %0d expected 320", x_position); end
    n_cmp++; if (y_position !== 9'd236) begin n_bad++; $display("FAIL ovf_y: got %0d expected 236", y_position); end
    n_cmp++; if (po !== 1'b1) begin n_bad++; $display("FAIL ovf_pv: got %b expected 1", po); end
    send_packet(8'h8A, 8'h02, 8'h40, pu, po, mo, pa, ma);
    n_cmp++; if (x_position !== 10'd322) begin n_bad++; $display("FAIL yovf_x: got %0d expected 322", x_position); end
    n_cmp++; if (y_position !== 9'd236) begin n_bad++; $display("FAIL yovf_y: got %0d expected 236", y_position); end
    n_cmp++; if (right_pressed !== 1'b1) begin n_bad++; $display("FAIL yovf_right: got %b expected 1", right_pressed); end
  endtask

  task automatic test_resync();
    logic pu, po, mo, pa, ma, se1, se2;
    do_reset();
    send_byte(8'h00);
    se1 = sync_error;
    @(posedge CLOCK_50); #1;
    se2 = sync_error;
    n_cmp++; if (se1 !== 1'b1) begin n_bad++; $display("FAIL resync_err: got %b expected 1", se1); end
    n_cmp++; if (se2 !== 1'b0) begin n_bad++; $display("FAIL resync_err_once: got %b expected 0", se2); end
    send_byte(8'hFA);
    n_cmp++; if (sync_error !== 1'b0) begin n_bad++; $display("FAIL resync_ack: got %b expected 0", sync_error); end
    send_packet(8'h09, 8'h00, 8'h00, pu, po, mo, pa, ma);
    n_cmp++; if (left_pressed !== 1'b1) begin n_bad++; $display("FAIL resync_left: got %b expected 1", left_pressed); end
    n_cmp++; if (mo !== 1'b1) begin n_bad++; $display("FAIL resync_press: got %b expected 1", mo); end
    n_cmp++; if (ma !== 1'b0) begin n_bad++; $display("FAIL resync_press_once: got %b expected 0", ma); end
    n_cmp++; if ({x_position, y_position} !== {10'd320, 9'd240}) begin n_bad++; $display("FAIL resync_pos: got %0d,%0d expected 320,240", x_position, y_position); end
    send_packet(8'h09, 8'h00, 8'h00, pu, po, mo, pa, ma);
    n_cmp++; if (mo !== 1'b0) begin n_bad++; $display("FAIL resync_no_repress: got %b expected 0", mo); end
    send_packet(8'h0E, 8'h00, 8'h00, pu, po, mo, pa, ma);
    n_cmp++; if ({left_pressed, right_pressed, middle_pressed} !== 3'b011) begin n_bad++; $display("FAIL buttons_rm: got %b expected 011", {left_pressed, right_pressed, middle_pressed}); end
    n_cmp++; if (mo !== 1'b0) begin n_bad++; $display("FAIL release_no_press: got %b expected 0", mo); end
    send_packet(8'h09, 8'h00, 8'h00, pu, po, mo, pa, ma);
    n_cmp++; if (mo !== 1'b1) begin n_bad++; $display("FAIL repress: got %b expected 1", mo); end
  endtask

  task automatic test_reset_mid_packet();
    logic pu, po, mo, pa, ma;
    do_reset();
    send_packet(8'h09, 8'h05, 8'h05, pu, po, mo, pa, ma);
    send_byte(8'h08);
    send_byte(8'h10);
    do_reset();
    n_cmp++; if ({x_position, y_position} !== {10'd320, 9'd240}) begin n_bad++; $display("FAIL midrst_pos: got %0d,%0d expected 320,240", x_position, y_position); end
    n_cmp++; if (left_pressed !== 1'b0) begin n_bad++; $display("FAIL midrst_left: got %b expected 0", left_pressed); end
    send_packet(8'h08, 8'h01, 8'h01, pu, po, mo, pa, ma);
    n_cmp++; if ({x_position, y_position} !== {10'd321, 9'd239}) begin n_bad++; $display("FAIL midrst_resume: got %0d,%0d expected 321,239", x_position, y_position); end
    n_cmp++; if (po !== 1'b1) begin n_bad++; $display("FAIL midrst_pv: got %b expected 1", po); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_clamp();
    test_overflow();
    test_resync();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
